// File: rtl/wash_pkg.sv
// Shared types and the program table for the wash program sequencer.
//   phase_e      : sequencer state, also driven out on the phase port
//   prog_t       : per-program timing in ticks {wash, rinse, spin, rinses}
//   prog_lookup  : program table indexed by prog_sel
//   table_fits   : true when every table value fits a counter of the given width
package wash_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WASH      = 3'd1,
    WAIT_SPIN = 3'd2,
    SPIN      = 3'd3,
    WAIT_WASH = 3'd4,
    WAIT_DONE = 3'd5
  } phase_e;

  typedef struct packed {
    logic [7:0] wash;
    logic [7:0] rinse;
    logic [7:0] spin;
    logic [1:0] rinses;
  } prog_t;

  localparam logic [1:0] PROG_QUICK  = 2'd0;
  localparam logic [1:0] PROG_NORMAL = 2'd1;
  localparam logic [1:0] PROG_HEAVY  = 2'd2;
  localparam logic [1:0] PROG_RINSE  = 2'd3;

  function automatic prog_t prog_lookup(input logic [1:0] sel);
    prog_t p;
    case (sel)
      PROG_QUICK:  p = '{wash: 8'd4,  rinse: 8'd2, spin: 8'd2, rinses: 2'd0};
      PROG_NORMAL: p = '{wash: 8'd10, rinse: 8'd6, spin: 8'd4, rinses: 2'd1};
      PROG_HEAVY:  p = '{wash: 8'd20, rinse: 8'd8, spin: 8'd6, rinses: 2'd2};
      default:     p = '{wash: 8'd2,  rinse: 8'd2, spin: 8'd3, rinses: 2'd0};
    endcase
    return p;
  endfunction

  function automatic bit table_fits(input int unsigned w);
    int unsigned mx;
    prog_t p;
    mx = 0;
    for (int i = 0; i < 4; i++) begin
      p = prog_lookup(2'(i));
      if (32'(p.wash)  > mx) mx = 32'(p.wash);
      if (32'(p.rinse) > mx) mx = 32'(p.rinse);
      if (32'(p.spin)  > mx) mx = 32'(p.spin);
    end
    return (w >= 32) || (mx <= ((32'd1 << w) - 32'd1));
  endfunction

endpackage

// File: rtl/wash_program_sequencer_tick_gen.sv
// Time-base prescaler for the wash program sequencer.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : restart the prescaler (held while no timed phase is running)
//   en       : count enable
//   tick     : one-cycle pulse every CLK_DIV enabled cycles after clr
module wash_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  // Combinational so the FSM sees the tick on the same edge the prescaler wraps.
  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/wash_program_sequencer.sv
// Program sequencer that paces the washing-machine FSM: it decodes the FSM's
// actuator outputs into wash/spin conditions, times each phase of the selected
// program and returns the cycleTO / spinTO / againwash timeouts.
//   clk, reset          : clock, asynchronous active-high reset
//   prog_sel, prog_load : program select, latched only in IDLE
//   motor_on, water_wash, done : from the washing-machine FSM
//   cycleTO, spinTO, againwash : registered one-cycle timeouts to the FSM
//   phase, time_left, rinse_left, busy, err : status
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for a wash to start; program may be loaded
// WASH      | timing a wash or rinse phase
// WAIT_SPIN | wash/rinse expired, waiting for the spin to start
// SPIN      | timing a spin phase
// WAIT_WASH | spin expired with rinses left, waiting for rinse water
// WAIT_DONE | last spin expired, waiting for the FSM's done
module wash_program_sequencer
  import wash_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       prog_sel,
  input  logic             prog_load,
  input  logic             motor_on,
  input  logic             water_wash,
  input  logic             done,
  output logic             cycleTO,
  output logic             spinTO,
  output logic             againwash,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] time_left,
  output logic [1:0]       rinse_left,
  output logic             busy,
  output logic             err
);

  localparam bit TABLE_OK = table_fits(CNT_W);

  phase_e           state, state_n;
  logic [CNT_W-1:0] tl_n;
  logic [1:0]       rl_n;
  logic [1:0]       prog, prog_n;
  logic             cyc_n, spin_n, aw_n, err_n;
  logic             load, timed, tick;
  logic             washc, spinc;
  prog_t            cur;

  assign washc = motor_on & water_wash;
  assign spinc = motor_on & ~water_wash;
  assign timed = (state == WASH) || (state == SPIN);

  wash_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (reset),
    .clr  (load | ~timed),
    .en   (timed),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    tl_n    = time_left;
    rl_n    = rinse_left;
    prog_n  = prog;
    err_n   = err;
    cyc_n   = 1'b0;
    spin_n  = 1'b0;
    aw_n    = 1'b0;
    load    = 1'b0;
    cur     = prog_lookup(prog);

    case (state)
      IDLE: begin
        // A load in the same cycle as the wash start already governs that wash.
        if (prog_load) begin
          prog_n = prog_sel;
          err_n  = 1'b0;
          cur    = prog_lookup(prog_sel);
        end
        if (washc) begin
          state_n = WASH;
          tl_n    = CNT_W'(cur.wash);
          rl_n    = cur.rinses;
          load    = 1'b1;
        end
      end
      WASH: begin
        if (!washc) begin
          state_n = IDLE;
          err_n   = 1'b1;
          tl_n    = '0;
          rl_n    = '0;
        end else if (tick) begin
          if (time_left == CNT_W'(1)) begin
            cyc_n   = 1'b1;
            tl_n    = '0;
            state_n = WAIT_SPIN;
          end else begin
            tl_n = time_left - 1'b1;
          end
        end
      end
      WAIT_SPIN: begin
        if (spinc) begin
          state_n = SPIN;
          tl_n    = CNT_W'(cur.spin);
          load    = 1'b1;
        end
      end
      SPIN: begin
        if (!spinc) begin
          state_n = IDLE;
          err_n   = 1'b1;
          tl_n    = '0;
          rl_n    = '0;
        end else if (tick) begin
          if (time_left == CNT_W'(1)) begin
            spin_n = 1'b1;
            aw_n   = (rinse_left != 2'd0);
            tl_n   = '0;
            if (rinse_left != 2'd0) begin
              rl_n    = rinse_left - 1'b1;
              state_n = WAIT_WASH;
            end else begin
              state_n = WAIT_DONE;
            end
          end else begin
            tl_n = time_left - 1'b1;
          end
        end
      end
      WAIT_WASH: begin
        if (washc) begin
          state_n = WASH;
          tl_n    = CNT_W'(cur.rinse);
          load    = 1'b1;
        end
      end
      WAIT_DONE: ;
      default: state_n = IDLE;
    endcase

    // done ends the run cleanly from anywhere; a pulse expiring on the same
    // edge is still delivered, and a concurrent condition drop is not an error.
    if (state != IDLE && done) begin
      state_n = IDLE;
      tl_n    = '0;
      rl_n    = '0;
      err_n   = err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prog       <= PROG_NORMAL;
      time_left  <= '0;
      rinse_left <= '0;
      cycleTO    <= 1'b0;
      spinTO     <= 1'b0;
      againwash  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      prog       <= prog_n;
      time_left  <= tl_n;
      rinse_left <= rl_n;
      cycleTO    <= cyc_n;
      spinTO     <= spin_n;
      againwash  <= aw_n;
      err        <= err_n;
    end
  end

  assign phase = state;
  assign busy  = (state != IDLE);

  // Program table must fit in the phase counter.
  table_fits_a: assert property (@(posedge clk) TABLE_OK);

endmodule

// File: tb/tb_wash_program_sequencer.sv
module tb_wash_program_sequencer;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] prog_sel = 2'd0;
  logic       prog_load = 1'b0;
  logic       motor_on = 1'b0;
  logic       water_wash = 1'b0;
  logic       done = 1'b0;
  logic       cycleTO, spinTO, againwash, busy, err;
  logic [2:0] phase;
  logic [7:0] time_left;
  logic [1:0] rinse_left;

  wash_program_sequencer #(.CLK_DIV(D), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_sel   (prog_sel),
    .prog_load  (prog_load),
    .motor_on   (motor_on),
    .water_wash (water_wash),
    .done       (done),
    .cycleTO    (cycleTO),
    .spinTO     (spinTO),
    .againwash  (againwash),
    .phase      (phase),
    .time_left  (time_left),
    .rinse_left (rinse_left),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference program table (ticks): wash / rinse / spin / rinses.
  int wash_t  [4] = '{4, 10, 20, 2};
  int rinse_t [4] = '{2, 6, 8, 2};
  int spin_t  [4] = '{2, 4, 6, 3};
  int rinses_t[4] = '{0, 1, 2, 0};

  typedef struct {
    bit spin;
    bit aw;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        e = exp_q.pop_front();
        chk("pulse_missing_at", e.at, cyc);
      end
      if (cycleTO || spinTO) begin
        chk("pulse_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pulse_kind_spin", int'(spinTO), int'(e.spin));
          chk("pulse_kind_cycle", int'(cycleTO), int'(!e.spin));
          chk("pulse_againwash", int'(againwash), int'(e.aw));
          chk("pulse_cycle", cyc, e.at);
        end
      end
      if (!spinTO) chk("againwash_without_spin", int'(againwash), 0);
    end
  end

  task automatic set_wash(); motor_on = 1'b1; water_wash = 1'b1; endtask
  task automatic set_spin(); motor_on = 1'b1; water_wash = 1'b0; endtask
  task automatic set_off();  motor_on = 1'b0; water_wash = 1'b0; endtask

  // Called #1 after a clock edge with the sequencer in IDLE.
  task automatic run_program(input int sel, input bit same_cycle, input int abort_p,
                             input int abort_k, input bit early_done);
    int nph, t, k, rl, w;
    bit is_spin;
    nph = 2 * (1 + rinses_t[sel]);
    rl  = rinses_t[sel];
    prog_sel = 2'(sel);
    if (!same_cycle) begin
      prog_load = 1'b1;
      @(posedge clk); #1;
      prog_load = 1'b0;
      chk("err_after_load", int'(err), 0);
    end else begin
      prog_load = 1'b1;
    end
    for (int p = 0; p < nph; p++) begin
      is_spin = (p % 2 == 1);
      t = (p == 0) ? wash_t[sel] : (is_spin ? spin_t[sel] : rinse_t[sel]);
      if (is_spin) set_spin(); else set_wash();
      if (p == abort_p) begin
        k = (abort_k > t * D) ? t * D : abort_k;
        repeat (k) @(posedge clk);
        #1;
        prog_load = 1'b0;
        set_off();
        @(posedge clk); #1;
        chk("abort_err", int'(err), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_time_left", int'(time_left), 0);
        chk("abort_phase", int'(phase), 0);
        return;
      end
      exp_q.push_back('{spin: is_spin, aw: is_spin && (rl > 0), at: cyc + 1 + t * D});
      @(posedge clk); #1;
      prog_load = 1'b0;
      chk("phase_start_time_left", int'(time_left), t);
      chk("phase_start_phase", int'(phase), is_spin ? 3 : 1);
      if (p == 0) begin
        chk("start_err_clear", int'(err), 0);
        chk("start_rinse_left", int'(rinse_left), rinses_t[sel]);
      end
      if ($urandom_range(0, 1) == 1) begin
        prog_load = 1'b1;
        prog_sel = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
        prog_load = 1'b0;
        repeat (t * D - 1) @(posedge clk);
      end else begin
        repeat (t * D) @(posedge clk);
      end
      #1;
      if (is_spin && rl > 0) rl--;
      chk("expiry_time_left", int'(time_left), 0);
      chk("expiry_rinse_left", int'(rinse_left), rl);
      if (p < nph - 1) begin
        w = $urandom_range(0, 3);
        if (early_done && p == 0) begin
          set_off();
          done = 1'b1;
          @(posedge clk); #1;
          done = 1'b0;
          chk("early_done_busy", int'(busy), 0);
          chk("early_done_err", int'(err), 0);
          return;
        end
        if (is_spin || $urandom_range(0, 1) == 0) set_off();
        repeat (w) @(posedge clk);
        if (w > 0) #1;
      end
    end
    set_off();
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    chk("wait_done_busy", int'(busy), 1);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("done_busy", int'(busy), 0);
    chk("done_phase", int'(phase), 0);
    chk("done_err", int'(err), 0);
  endtask

  initial begin
    int nph, ap, guard;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cycleTO", int'(cycleTO), 0);
    chk("rst_spinTO", int'(spinTO), 0);
    chk("rst_time_left", int'(time_left), 0);
    chk("rst_rinse_left", int'(rinse_left), 0);
    chk("rst_phase", int'(phase), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed: each program once, load both ways.
    run_program(0, 1'b1, -1, 0, 1'b0);
    run_program(1, 1'b0, -1, 0, 1'b0);
    run_program(2, 1'b1, -1, 0, 1'b0);
    run_program(3, 1'b0, -1, 0, 1'b0);
    // Abort at tick 5 of the 10-tick normal wash, then a load clears err.
    run_program(1, 1'b0, 0, 5 * D, 1'b0);
    run_program(0, 1'b0, -1, 0, 1'b0);
    // Spin condition drops on the expiring edge: abort wins.
    run_program(0, 1'b1, 1, 1000, 1'b0);
    run_program(2, 1'b1, 3, 1000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      nph = 2 * (1 + rinses_t[sel]);
      ap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nph - 1) : -1;
      run_program(sel, 1'($urandom_range(0, 1)), ap, $urandom_range(1, 40),
                  ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset during the final tick of a spin: no spinTO, outputs clear at once.
    prog_sel = 2'd0;
    prog_load = 1'b1;
    set_wash();
    exp_q.push_back('{spin: 1'b0, aw: 1'b0, at: cyc + 1 + wash_t[0] * D});
    @(posedge clk); #1;
    prog_load = 1'b0;
    repeat (wash_t[0] * D) @(posedge clk);
    #1;
    set_spin();
    @(posedge clk); #1;
    chk("rst_test_spin_phase", int'(phase), 3);
    guard = 0;
    while (time_left != 8'd1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_test_reach_tl1", int'(time_left), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_spinTO", int'(spinTO), 0);
    chk("async_rst_cycleTO", int'(cycleTO), 0);
    chk("async_rst_againwash", int'(againwash), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_err", int'(err), 0);
    chk("async_rst_time_left", int'(time_left), 0);
    chk("async_rst_rinse_left", int'(rinse_left), 0);
    chk("async_rst_phase", int'(phase), 0);
    repeat (3) @(posedge clk);
    set_off();
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Reset restores the normal program; done mid-wash ends without err.
    set_wash();
    @(posedge clk); #1;
    chk("default_prog_wash", int'(time_left), wash_t[1]);
    chk("default_prog_rinses", int'(rinse_left), rinses_t[1]);
    set_off();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("done_in_wash_busy", int'(busy), 0);
    chk("done_in_wash_err", int'(err), 0);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_pulses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
